// File: rtl/screen_pkg.sv
// screen_pkg: default screen geometry and helpers shared by the framebuffer and its RAM.
package screen_pkg;
    localparam int DEF_WORD_W = 16;
    localparam int DEF_COLS   = 512;
    localparam int DEF_ROWS   = 256;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    function automatic int screen_addr_w(input int rows, input int cols, input int word_w);
        return $clog2(rows * cols / word_w);
    endfunction

    function automatic int screen_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction
endpackage

// File: rtl/screen_dpram.sv
// screen_dpram: true dual-port RAM; port A read/write with write-through, port B read-only.
module screen_dpram #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [WORD_W-1:0] a_wdata_i,
    output logic [WORD_W-1:0] a_rdata_o,
    input  logic [ADDR_W-1:0] b_addr_i,
    output logic [WORD_W-1:0] b_rdata_o
);
    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] a_q, b_q;

    // Port B samples mem before this edge's write lands, so a collision yields old data.
    always_ff @(posedge clk) begin
        if (a_we_i) mem[a_addr_i] <= a_wdata_i;
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_we_i ? a_wdata_i : mem[a_addr_i];
            b_q <= mem[b_addr_i];
        end
    end

    assign a_rdata_o = a_q;
    assign b_rdata_o = b_q;
endmodule

// File: rtl/screen_fb.sv
// screen_fb: Hack screen framebuffer with CPU port and a 2-stage raster scan-out pipeline.
module screen_fb
    import screen_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int ADDR_W = screen_addr_w(ROWS, COLS, WORD_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load,
    output logic [WORD_W-1:0] out,
    input  logic              scan_en,
    output logic              pix,
    output logic              pix_valid,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);
    localparam int H_TOTAL = screen_total(COLS, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = screen_total(ROWS, V_FP, V_SYNC, V_BP);
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int BW = $clog2(WORD_W);

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic              h_last, act0, hs0, vs0, fs0;
    logic [ADDR_W-1:0] scan_addr;
    logic [BW-1:0]     bit0, bit1_q;
    logic              act1_q, hs1_q, vs1_q, fs1_q;
    logic [WORD_W-1:0] word1;
    logic              pix_q, pv_q, hs_q, vs_q, fs_q;

    screen_dpram #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_ram (
        .clk       (clk),
        .reset     (reset),
        .a_we_i    (load),
        .a_addr_i  (address),
        .a_wdata_i (in),
        .a_rdata_o (out),
        .b_addr_i  (scan_addr),
        .b_rdata_o (word1)
    );

    always_comb begin
        h_last    = h_q == HW'(H_TOTAL - 1);
        h_d       = !scan_en ? '0 : h_last ? '0 : h_q + 1'b1;
        v_d       = !scan_en ? '0 : !h_last ? v_q : (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
        act0      = scan_en && h_q < HW'(COLS) && v_q < VW'(ROWS);
        hs0       = scan_en && h_q >= HW'(COLS + H_FP) && h_q < HW'(COLS + H_FP + H_SYNC);
        vs0       = scan_en && v_q >= VW'(ROWS + V_FP) && v_q < VW'(ROWS + V_FP + V_SYNC);
        fs0       = scan_en && h_q == '0 && v_q == '0;
        scan_addr = ADDR_W'(v_q) * ADDR_W'(COLS / WORD_W) + ADDR_W'(h_q / HW'(WORD_W));
        bit0      = BW'(h_q % HW'(WORD_W));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q    <= '0;
            v_q    <= '0;
            act1_q <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            fs1_q  <= 1'b0;
            bit1_q <= '0;
            pix_q  <= 1'b0;
            pv_q   <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            act1_q <= act0;
            hs1_q  <= hs0;
            vs1_q  <= vs0;
            fs1_q  <= fs0;
            bit1_q <= bit0;
            pix_q  <= act1_q & word1[bit1_q];
            pv_q   <= act1_q;
            hs_q   <= hs1_q;
            vs_q   <= vs1_q;
            fs_q   <= fs1_q;
        end
    end

    assign pix         = pix_q;
    assign pix_valid   = pv_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_screen_fb.sv
// tb_screen_fb: random and directed checks of screen_fb against a frame-position reference model.
module tb_screen_fb;
    localparam int WW = 16, COLS = 32, ROWS = 4, HT = 38, VT = 7, FT = HT * VT, WPR = COLS / WW;

    typedef struct packed {
        logic pix;
        logic pv;
        logic hs;
        logic vs;
        logic fs;
    } desc_t;

    logic        clk = 1'b0, reset = 1'b1, load = 1'b0, scan_en = 1'b0;
    logic [15:0] din = '0, dout;
    logic [2:0]  addr = '0;
    logic        pix, pix_valid, hsync, vsync, frame_start;
    logic [15:0] mdl [8];
    desc_t       e1 = '0, e2 = '0;
    int          p = 0, n_chk = 0, n_pass = 0, k;
    int          s_pix, s_pv, s_hs, s_vs;

    screen_fb #(
        .WORD_W(WW), .COLS(COLS), .ROWS(ROWS),
        .H_FP(2), .H_SYNC(2), .H_BP(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk(clk), .reset(reset), .in(din), .address(addr), .load(load), .out(dout),
        .scan_en(scan_en), .pix(pix), .pix_valid(pix_valid), .hsync(hsync),
        .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // One clock: derive what the screen should show at frame position p, then compare after the edge.
    task automatic cyc();
        desc_t       d;
        logic [15:0] w, exp_out;
        int          h, v;
        h = p % HT;
        v = p / HT;
        d = '0;
        if (scan_en && !reset) begin
            d.pv = h < COLS && v < ROWS;
            if (d.pv) begin
                w     = mdl[v * WPR + h / WW];
                d.pix = w[h % WW];
            end
            d.hs = h >= 34 && h < 36;
            d.vs = v == 5;
            d.fs = p == 0;
        end
        exp_out = reset ? 16'h0 : load ? din : mdl[addr];
        if (load) mdl[addr] = din;
        if (reset) begin
            e1 = '0;
            e2 = '0;
        end else begin
            e2 = e1;
            e1 = d;
        end
        p = (reset || !scan_en) ? 0 : (p + 1) % FT;
        @(posedge clk);
        #1;
        chk("out", dout, exp_out);
        chk("pix", pix, e2.pix);
        chk("pix_valid", pix_valid, e2.pv);
        chk("hsync", hsync, e2.hs);
        chk("vsync", vsync, e2.vs);
        chk("frame_start", frame_start, e2.fs);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!frame_start && n < 400);
    endtask

    task automatic run_to(input int target);
        int g = 0;
        while (p != target && g < 400) begin
            cyc();
            g++;
        end
        chk("run_to", p, target);
    endtask

    task automatic acc();
        s_pix += int'(pix);
        s_pv  += int'(pix_valid);
        s_hs  += int'(hsync);
        s_vs  += int'(vsync);
    endtask

    initial begin
        repeat (3) cyc();
        chk("reset_out", {dout, pix, pix_valid, hsync, vsync, frame_start}, 0);
        reset = 1'b0;
        load = 1'b1; addr = 3'd5; din = 16'hBEEF;
        cyc();
        chk("write_through", dout, 16'hBEEF);
        load = 1'b0;
        cyc();
        chk("read_back", dout, 16'hBEEF);
        for (int i = 0; i < 8; i++) begin
            load = 1'b1;
            addr = 3'(i);
            din  = i == 0 ? 16'h0001 : i == 1 ? 16'h8000 : 16'h0000;
            cyc();
        end
        load = 1'b0;

        scan_en = 1'b1;
        wait_fs(k);
        chk("fs_latency", k, 2);
        s_pix = 0; s_pv = 0; s_hs = 0; s_vs = 0;
        acc();
        k = 0;
        do begin
            cyc();
            k++;
            if (!frame_start) acc();
        end while (!frame_start && k < 400);
        chk("fs_period", k, FT);
        chk("pv_count", s_pv, 128);
        chk("pix_count", s_pix, 2);
        chk("hs_count", s_hs, 14);
        chk("vs_count", s_vs, 38);

        run_to(HT);
        load = 1'b1; addr = 3'd2; din = 16'hA5A5;
        cyc();
        chk("collision_out", dout, 16'hA5A5);
        load = 1'b0;
        run_to(0);
        run_to(HT + 20);

        run_to(2 * HT + 20);
        reset = 1'b1;
        repeat (2) cyc();
        chk("reset_mid_zero", {dout, pix, pix_valid, hsync, vsync, frame_start}, 0);
        reset = 1'b0;
        wait_fs(k);
        chk("reset_restart", k, 2);

        run_to(5 * HT + 34);
        scan_en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            load = ($urandom_range(0, 3) == 0);
            addr = 3'($urandom_range(0, 7));
            din  = 16'($urandom);
            cyc();
        end
        load = 1'b0;
        chk("disabled_zero", {pix, pix_valid, hsync, vsync, frame_start}, 0);
        scan_en = 1'b1;
        wait_fs(k);
        chk("reenable_fs", k, 2);

        for (int i = 0; i < 3 * FT; i++) begin
            reset   = ($urandom_range(0, 499) == 0);
            scan_en = ($urandom_range(0, 149) != 0);
            load    = !reset && ($urandom_range(0, 3) == 0);
            addr    = 3'($urandom_range(0, 7));
            din     = 16'($urandom);
            cyc();
        end
        reset = 1'b0;
        load = 1'b0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
